// File: rtl/xm23_mem_interface_if.sv
// Request/response and byte-lane memory bus of the XM23 MAR/MDR controller.
//   master : requester side (control unit / bench); drives req_*, lane read data
//   slave  : controller side; drives req_ready, rsp_*, lane address/data/enables
interface xm23_mem_interface_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned BYTE_W = DATA_W / 2;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_byte;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_fault;

   logic [ADDR_W-1:0] mem_lb_addr;
   logic [ADDR_W-1:0] mem_ub_addr;
   logic [BYTE_W-1:0] mem_lb_wdata;
   logic [BYTE_W-1:0] mem_ub_wdata;
   logic              mem_lb_we;
   logic              mem_ub_we;
   logic [BYTE_W-1:0] mem_lb_rdata;
   logic [BYTE_W-1:0] mem_ub_rdata;

   modport master (
      output req_valid, req_write, req_byte, req_addr, req_wdata,
      output mem_lb_rdata, mem_ub_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
      input  mem_lb_addr, mem_ub_addr, mem_lb_wdata, mem_ub_wdata, mem_lb_we, mem_ub_we
   );

   modport slave (
      input  req_valid, req_write, req_byte, req_addr, req_wdata,
      input  mem_lb_rdata, mem_ub_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault,
      output mem_lb_addr, mem_ub_addr, mem_lb_wdata, mem_ub_wdata, mem_lb_we, mem_ub_we
   );
endinterface

// File: rtl/xm23_mem_interface.sv
// XM23 MAR/MDR memory-access controller: latches one byte/word request, drives the
// split lower/upper byte lanes (lb at MAR, ub at MAR+1), inserts WAIT_STATES extra
// cycles, checks word alignment and returns a single-cycle response.
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : slave view of xm23_mem_interface_if (req/rsp handshake + byte lanes)
module xm23_mem_interface #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_STATES = 1,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input logic               i_clk,
   input logic               i_rst,
   xm23_mem_interface_if.slave bus
);
   localparam int unsigned BYTE_W = DATA_W / 2;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_mdr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_write;
   logic              r_byte;
   logic              r_fault;
   logic              r_first;

   logic w_accept;
   logic w_fault;
   logic w_last;

   assign w_accept = bus.req_valid && (r_state == ST_IDLE);
   assign w_fault  = ALIGN_CHECK & ~bus.req_byte & bus.req_addr[0];
   assign w_last   = (r_cnt == '0);

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = w_fault ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (w_last)   w_state_nxt = ST_RESP;
         ST_RESP:                 w_state_nxt = ST_IDLE;
         default:                 w_state_nxt = ST_IDLE;
      endcase
   end

   // MAR/MDR, wait counter and latched request attributes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mar   <= '0;
         r_mdr   <= '0;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_byte  <= 1'b0;
         r_fault <= 1'b0;
         r_first <= 1'b0;
      end else begin
         // Enables are only valid in the first ACCESS cycle
         r_first <= w_accept & ~w_fault;
         if (w_accept) begin
            r_mar   <= bus.req_addr;
            r_write <= bus.req_write;
            r_byte  <= bus.req_byte;
            r_fault <= w_fault;
            r_cnt   <= CNT_W'(WAIT_STATES);
            // A faulted access reports zero data; byte accesses keep the upper lane clear
            if (w_fault)          r_mdr <= '0;
            else if (bus.req_byte) r_mdr <= {{BYTE_W{1'b0}}, bus.req_wdata[BYTE_W-1:0]};
            else                  r_mdr <= bus.req_wdata;
         end else if (r_state == ST_ACCESS) begin
            if (!w_last) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end else if (!r_write) begin
               if (r_byte) r_mdr <= {{BYTE_W{1'b0}}, bus.mem_lb_rdata};
               else        r_mdr <= {bus.mem_ub_rdata, bus.mem_lb_rdata};
            end
         end
      end
   end

   // Outputs decoded from state or taken straight from registers
   assign bus.req_ready    = (r_state == ST_IDLE);
   assign bus.rsp_valid    = (r_state == ST_RESP);
   assign bus.rsp_fault    = (r_state == ST_RESP) & r_fault;
   assign bus.rsp_rdata    = r_mdr;
   assign bus.mem_lb_addr  = r_mar;
   assign bus.mem_ub_addr  = r_mar + ADDR_W'(1);
   assign bus.mem_lb_wdata = r_mdr[BYTE_W-1:0];
   assign bus.mem_ub_wdata = r_mdr[DATA_W-1:BYTE_W];
   assign bus.mem_lb_we    = (r_state == ST_ACCESS) & r_first & r_write;
   assign bus.mem_ub_we    = (r_state == ST_ACCESS) & r_first & r_write & ~r_byte;
endmodule

// File: tb/tb_xm23_mem_interface.sv
// Bench for xm23_mem_interface: dut_a (WAIT_STATES=1, ALIGN_CHECK=1) and
// dut_b (WAIT_STATES=0, ALIGN_CHECK=0) share one byte-addressed memory model.
module tb_xm23_mem_interface;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   xm23_mem_interface_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
   xm23_mem_interface_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

   xm23_mem_interface #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1), .ALIGN_CHECK(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst), .bus(ifa));
   xm23_mem_interface #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0), .ALIGN_CHECK(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst), .bus(ifb));

   // Byte memory model: combinational lane reads, lane writes on the rising edge
   logic [7:0]  mem [0:65535];
   logic        mem_clr = 1'b1;
   logic        pl_we   = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   assign ifa.mem_lb_rdata = mem[ifa.mem_lb_addr];
   assign ifa.mem_ub_rdata = mem[ifa.mem_ub_addr];
   assign ifb.mem_lb_rdata = mem[ifb.mem_lb_addr];
   assign ifb.mem_ub_rdata = mem[ifb.mem_ub_addr];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      end else begin
         if (pl_we)         mem[pl_addr]         <= pl_data;
         if (ifa.mem_lb_we) mem[ifa.mem_lb_addr] <= ifa.mem_lb_wdata;
         if (ifa.mem_ub_we) mem[ifa.mem_ub_addr] <= ifa.mem_ub_wdata;
         if (ifb.mem_lb_we) mem[ifb.mem_lb_addr] <= ifb.mem_lb_wdata;
         if (ifb.mem_ub_we) mem[ifb.mem_ub_addr] <= ifb.mem_ub_wdata;
      end
   end

   typedef struct {
      logic [15:0] rdata;
      logic        fault;
      int          exp_cyc;
      logic [15:0] lb_addr;
      logic [15:0] ub_addr;
   } rsp_t;

   typedef struct {
      logic [15:0] lb_addr;
      logic [15:0] ub_addr;
      logic [7:0]  lb_wd;
      logic [7:0]  ub_wd;
      logic        lb_we;
      logic        ub_we;
   } wr_t;

   rsp_t q_rsp_a[$];
   rsp_t q_rsp_b[$];
   wr_t  q_wr_a[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_event(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
   endtask

   task automatic preload(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = addr; pl_data = data;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   // Issue one request and push its expected response (and lane write, if any)
   task automatic send(input bit sel_b, input logic wr, input logic by,
                       input logic [15:0] addr, input logic [15:0] wd, input int lat,
                       input logic [15:0] exp_rd, input logic exp_flt,
                       input logic [7:0] exp_lb_wd, input logic [7:0] exp_ub_wd);
      int   n;
      logic rdy;
      rsp_t r;
      wr_t  w;
      @(negedge clk);
      if (sel_b) begin
         ifb.req_valid = 1'b1; ifb.req_write = wr; ifb.req_byte = by;
         ifb.req_addr = addr; ifb.req_wdata = wd;
      end else begin
         ifa.req_valid = 1'b1; ifa.req_write = wr; ifa.req_byte = by;
         ifa.req_addr = addr; ifa.req_wdata = wd;
      end
      n = 0;
      rdy = sel_b ? ifb.req_ready : ifa.req_ready;
      while (rdy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
         rdy = sel_b ? ifb.req_ready : ifa.req_ready;
      end
      if (n >= 50) begin
         check("accept_timeout", 32'(n), 32'd0);
      end else begin
         r.rdata = exp_rd; r.fault = exp_flt; r.exp_cyc = cyc + lat;
         r.lb_addr = addr; r.ub_addr = addr + 16'd1;
         if (sel_b) q_rsp_b.push_back(r);
         else       q_rsp_a.push_back(r);
         if (wr && !exp_flt && !sel_b) begin
            w.lb_addr = addr; w.ub_addr = addr + 16'd1;
            w.lb_wd = exp_lb_wd; w.ub_wd = exp_ub_wd;
            w.lb_we = 1'b1; w.ub_we = ~by;
            q_wr_a.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      if (sel_b) ifb.req_valid = 1'b0;
      else       ifa.req_valid = 1'b0;
   endtask

   // Monitor A: responses and lane writes
   rsp_t ra;
   wr_t  wa;
   always @(negedge clk) begin
      if (!rst) begin
         if (ifa.rsp_valid) begin
            if (q_rsp_a.size() == 0) begin
               fail_event("a_rsp_unexpected");
            end else begin
               ra = q_rsp_a.pop_front();
               check("a_rdata",   32'(ifa.rsp_rdata),   32'(ra.rdata));
               check("a_fault",   32'(ifa.rsp_fault),   32'(ra.fault));
               check("a_latency", 32'(cyc),             32'(ra.exp_cyc));
               check("a_lb_addr", 32'(ifa.mem_lb_addr), 32'(ra.lb_addr));
               check("a_ub_addr", 32'(ifa.mem_ub_addr), 32'(ra.ub_addr));
            end
         end
         if (ifa.mem_lb_we || ifa.mem_ub_we) begin
            if (q_wr_a.size() == 0) begin
               fail_event("a_we_unexpected");
            end else begin
               wa = q_wr_a.pop_front();
               check("a_wr_lb_addr", 32'(ifa.mem_lb_addr),  32'(wa.lb_addr));
               check("a_wr_ub_addr", 32'(ifa.mem_ub_addr),  32'(wa.ub_addr));
               check("a_wr_lb_data", 32'(ifa.mem_lb_wdata), 32'(wa.lb_wd));
               check("a_wr_lb_we",   32'(ifa.mem_lb_we),    32'(wa.lb_we));
               check("a_wr_ub_we",   32'(ifa.mem_ub_we),    32'(wa.ub_we));
               if (wa.ub_we) check("a_wr_ub_data", 32'(ifa.mem_ub_wdata), 32'(wa.ub_wd));
            end
         end
      end
   end

   // Monitor B: responses only; any lane write is unexpected
   rsp_t rb;
   always @(negedge clk) begin
      if (!rst) begin
         if (ifb.rsp_valid) begin
            if (q_rsp_b.size() == 0) begin
               fail_event("b_rsp_unexpected");
            end else begin
               rb = q_rsp_b.pop_front();
               check("b_rdata",   32'(ifb.rsp_rdata),   32'(rb.rdata));
               check("b_fault",   32'(ifb.rsp_fault),   32'(rb.fault));
               check("b_latency", 32'(cyc),             32'(rb.exp_cyc));
               check("b_lb_addr", 32'(ifb.mem_lb_addr), 32'(rb.lb_addr));
               check("b_ub_addr", 32'(ifb.mem_ub_addr), 32'(rb.ub_addr));
            end
         end
         if (ifb.mem_lb_we || ifb.mem_ub_we) fail_event("b_we_unexpected");
      end
   end

   initial begin
      int n;
      ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_byte = 1'b0;
      ifa.req_addr = '0; ifa.req_wdata = '0;
      ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_byte = 1'b0;
      ifb.req_addr = '0; ifb.req_wdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mem_clr = 1'b0;
      #1;
      check("rst_ready",  32'(ifa.req_ready), 32'd1);
      check("rst_valid",  32'(ifa.rsp_valid), 32'd0);
      check("rst_fault",  32'(ifa.rsp_fault), 32'd0);
      check("rst_lb_we",  32'(ifa.mem_lb_we), 32'd0);
      check("rst_ub_we",  32'(ifa.mem_ub_we), 32'd0);
      check("rst_rdata",  32'(ifa.rsp_rdata), 32'h0000);
      check("rst_b_ready", 32'(ifb.req_ready), 32'd1);

      preload(16'h0104, 8'h77);
      preload(16'hFFFF, 8'h5A);
      preload(16'h0000, 8'hC3);

      //   sel wr  by  addr      wdata     lat rdata     flt  lb_wd  ub_wd
      send(0, 1, 0, 16'h0100, 16'hBEEF, 3, 16'hBEEF, 0, 8'hEF, 8'hBE);
      send(0, 0, 0, 16'h0100, 16'h0000, 3, 16'hBEEF, 0, 8'h00, 8'h00);
      send(0, 0, 1, 16'h0101, 16'h0000, 3, 16'h00BE, 0, 8'h00, 8'h00);
      send(0, 1, 1, 16'h0103, 16'h12AB, 3, 16'h00AB, 0, 8'hAB, 8'h00);
      send(0, 0, 0, 16'h0102, 16'h0000, 3, 16'hAB00, 0, 8'h00, 8'h00);
      send(0, 0, 1, 16'h0104, 16'h0000, 3, 16'h0077, 0, 8'h00, 8'h00);
      send(0, 0, 0, 16'h0101, 16'hFFFF, 1, 16'h0000, 1, 8'h00, 8'h00);
      send(0, 0, 0, 16'h0100, 16'h0000, 3, 16'hBEEF, 0, 8'h00, 8'h00);
      send(0, 1, 0, 16'h0200, 16'h1234, 3, 16'h1234, 0, 8'h34, 8'h12);
      send(0, 0, 1, 16'h0200, 16'h0000, 3, 16'h0034, 0, 8'h00, 8'h00);
      send(1, 0, 0, 16'hFFFF, 16'h0000, 2, 16'hC35A, 0, 8'h00, 8'h00);
      send(1, 0, 0, 16'h0101, 16'h0000, 2, 16'h00BE, 0, 8'h00, 8'h00);

      // Let outstanding responses drain before the abort test
      n = 0;
      while ((q_rsp_a.size() != 0 || q_rsp_b.size() != 0 || q_wr_a.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_rsp_a", 32'(q_rsp_a.size()), 32'd0);
      check("drain_rsp_b", 32'(q_rsp_b.size()), 32'd0);
      check("drain_wr_a",  32'(q_wr_a.size()),  32'd0);

      // Reset during the first ACCESS cycle of a word write
      @(negedge clk);
      ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_byte = 1'b0;
      ifa.req_addr = 16'h0300; ifa.req_wdata = 16'h5555;
      check("abort_ready", 32'(ifa.req_ready), 32'd1);
      @(posedge clk);
      #1;
      ifa.req_valid = 1'b0;
      check("abort_we_pre", 32'(ifa.mem_lb_we), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_lb_we",  32'(ifa.mem_lb_we), 32'd0);
      check("abort_ub_we",  32'(ifa.mem_ub_we), 32'd0);
      check("abort_valid",  32'(ifa.rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_abort_ready", 32'(ifa.req_ready), 32'd1);
         check("post_abort_valid", 32'(ifa.rsp_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
